// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths, state encoding and saturation helper for the nn layers
package nn_pkg;

  localparam int WEIGHT_W = 8;
  localparam int FEAT_W   = 8;
  localparam int ACT_W    = 10;
  localparam int N_HID    = 8;
  localparam logic [ACT_W-1:0] ACT_MAX = 10'd1023;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Clamp an already-shifted accumulator value into the activation range.
  function automatic logic [ACT_W-1:0] sat10(input logic [31:0] v);
    if (v > 32'(ACT_MAX)) begin
      sat10 = ACT_MAX;
    end else begin
      sat10 = v[ACT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - shared 8x8 multiplier with clearable running accumulator
module mac_unit
  import nn_pkg::*;
#(
  parameter int ACC_W = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FEAT_W-1:0]   feat,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic                clr,
  input  logic                en,
  output logic [ACC_W-1:0]    acc,
  output logic [ACC_W-1:0]    sum
);

  logic [FEAT_W+WEIGHT_W-1:0] prod;

  // Product and the accumulator value this edge would produce; the
  // parent needs the latter to finish a neuron in the same cycle.
  always_comb begin
    prod = (FEAT_W+WEIGHT_W)'(feat) * (FEAT_W+WEIGHT_W)'(weight);
    sum  = acc + ACC_W'(prod);
  end

  // Accumulate while enabled; clear takes priority so the last term of a
  // neuron is consumed by the parent and the next neuron starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/hidden_layer.sv
// rtl/hidden_layer.sv - time-multiplexed 8-neuron hidden layer with one shared MAC
module hidden_layer
  import nn_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int FRAC_BITS = 7
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [N_IN*FEAT_W-1:0]        feat_i,
  input  logic                          wr_en_i,
  input  logic [$clog2(N_IN*N_HID)-1:0] wr_addr_i,
  input  logic [WEIGHT_W-1:0]           wr_data_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [ACT_W-1:0]              x0_o,
  output logic [ACT_W-1:0]              x1_o,
  output logic [ACT_W-1:0]              x2_o,
  output logic [ACT_W-1:0]              x3_o,
  output logic [ACT_W-1:0]              x4_o,
  output logic [ACT_W-1:0]              x5_o,
  output logic [ACT_W-1:0]              x6_o,
  output logic [ACT_W-1:0]              x7_o
);

  localparam int N_W   = N_IN * N_HID;
  localparam int AW    = $clog2(N_W);
  localparam int JW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ACC_W = FEAT_W + WEIGHT_W + $clog2(N_IN) + 1;

  logic [1:0]             state;
  logic [1:0]             next_state;
  logic [AW-1:0]          idx;
  logic [JW-1:0]          j;
  logic [2:0]             h;
  logic [N_IN*FEAT_W-1:0] feat_q;
  logic [WEIGHT_W-1:0]    w     [N_W];
  logic [ACT_W-1:0]       res   [N_HID];
  logic [ACT_W-1:0]       x_q   [N_HID];

  logic                   j_last;
  logic                   idx_last;
  logic                   mac_clr;
  logic                   mac_en;
  logic [FEAT_W-1:0]      cur_feat;
  logic [ACC_W-1:0]       mac_acc;
  logic [ACC_W-1:0]       mac_sum;
  logic [ACT_W-1:0]       new_act;

  // Operand selection and the finished activation for the current neuron.
  always_comb begin
    j_last   = (j == JW'(N_IN - 1));
    idx_last = (idx == AW'(N_W - 1));
    cur_feat = feat_q[FEAT_W*j +: FEAT_W];
    mac_en   = (state == S_MAC);
    mac_clr  = ((state == S_IDLE) && start_i) || ((state == S_MAC) && j_last);
    new_act  = sat10(32'(mac_sum >> FRAC_BITS));
  end

  mac_unit #(
    .ACC_W(ACC_W)
  ) u_mac (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .feat   (cur_feat),
    .weight (w[idx]),
    .clr    (mac_clr),
    .en     (mac_en),
    .acc    (mac_acc),
    .sum    (mac_sum)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: one pass of N_IN*8 MAC cycles, then a single DONE cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start_i)  next_state = S_MAC;
      S_MAC:   if (idx_last) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy_o = (state != S_IDLE);
    done_o = (state == S_DONE);
  end

  // Weight store, feature latch, counters and result/output registers.
  // Outputs are only refreshed on the final MAC edge so they never show a
  // partially computed vector; neuron 7 bypasses res since it finishes then.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx    <= '0;
      j      <= '0;
      h      <= '0;
      feat_q <= '0;
      for (int k = 0; k < N_W; k++) w[k] <= '0;
      for (int k = 0; k < N_HID; k++) begin
        res[k] <= '0;
        x_q[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_en_i && (int'(wr_addr_i) < N_W)) begin
            w[wr_addr_i] <= wr_data_i;
          end
          if (start_i) begin
            feat_q <= feat_i;
            idx    <= '0;
            j      <= '0;
            h      <= '0;
          end
        end
        S_MAC: begin
          idx <= idx + 1'b1;
          if (j_last) begin
            j      <= '0;
            h      <= h + 1'b1;
            res[h] <= new_act;
          end else begin
            j <= j + 1'b1;
          end
          if (idx_last) begin
            for (int k = 0; k < N_HID; k++) begin
              x_q[k] <= (3'(k) == h) ? new_act : res[k];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Flatten the output register array onto the named ports.
  always_comb begin
    x0_o = x_q[0];
    x1_o = x_q[1];
    x2_o = x_q[2];
    x3_o = x_q[3];
    x4_o = x_q[4];
    x5_o = x_q[5];
    x6_o = x_q[6];
    x7_o = x_q[7];
  end

endmodule

// File: tb/tb_hidden_layer.sv
// tb/tb_hidden_layer.sv - directed self-checking bench for hidden_layer
module tb_hidden_layer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] feat_i;
  logic        wr_en_i;
  logic [4:0]  wr_addr_i;
  logic [7:0]  wr_data_i;
  logic        busy_o;
  logic        done_o;
  logic [9:0]  x0_o, x1_o, x2_o, x3_o, x4_o, x5_o, x6_o, x7_o;
  logic [9:0]  xs [8];

  int total  = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  hidden_layer dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .feat_i    (feat_i),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .x0_o      (x0_o),
    .x1_o      (x1_o),
    .x2_o      (x2_o),
    .x3_o      (x3_o),
    .x4_o      (x4_o),
    .x5_o      (x5_o),
    .x6_o      (x6_o),
    .x7_o      (x7_o)
  );

  always_comb begin
    xs[0] = x0_o; xs[1] = x1_o; xs[2] = x2_o; xs[3] = x3_o;
    xs[4] = x4_o; xs[5] = x5_o; xs[6] = x6_o; xs[7] = x7_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all_x(input string tag, input logic [9:0] exp [8]);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_x%0d", tag, k), 32'(xs[k]), 32'(exp[k]));
    end
  endtask

  task automatic write_w(input int addr, input int data);
    @(negedge clk_i);
    wr_en_i   = 1'b1;
    wr_addr_i = 5'(addr);
    wr_data_i = 8'(data);
    @(negedge clk_i);
    wr_en_i   = 1'b0;
  endtask

  task automatic fill_w(input int data);
    for (int a = 0; a < 32; a++) write_w(a, data);
  endtask

  // Pulse start for one edge; returns the cycle count to done (0 = timeout).
  task automatic run(input logic [31:0] f, output int cyc);
    @(negedge clk_i);
    feat_i  = f;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    feat_i  = 32'hDEAD_BEEF;
    cyc = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk_i);
      if (done_o) begin
        cyc = n;
        break;
      end
    end
  endtask

  logic [9:0] exp_x [8];
  int cyc;
  int dones;

  initial begin
    rst_i     = 1'b1;
    start_i   = 1'b0;
    feat_i    = '0;
    wr_en_i   = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;

    // Test 1: asynchronous reset mid-cycle
    #3 rst_i = 1'b0;
    #1;
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    for (int k = 0; k < 8; k++) exp_x[k] = 10'd0;
    check_all_x("rst", exp_x);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Test 2: unity weights, features 10/20/30/40 -> 100 each
    fill_w(128);
    run({8'd40, 8'd30, 8'd20, 8'd10}, cyc);
    check("t2_latency", 32'(cyc), 33);
    check("t2_busy_in_done", 32'(busy_o), 1);
    for (int k = 0; k < 8; k++) exp_x[k] = 10'd100;
    check_all_x("t2", exp_x);
    @(negedge clk_i);
    check("t2_busy_after", 32'(busy_o), 0);
    check("t2_done_after", 32'(done_o), 0);

    // Test 5: start and weight write during MAC are dropped
    @(negedge clk_i);
    feat_i  = {8'd40, 8'd30, 8'd20, 8'd10};
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("t5_busy_mac", 32'(busy_o), 1);
    repeat (4) @(negedge clk_i);
    start_i   = 1'b1;
    wr_en_i   = 1'b1;
    wr_addr_i = 5'd0;
    wr_data_i = 8'd255;
    @(negedge clk_i);
    start_i = 1'b0;
    wr_en_i = 1'b0;
    dones = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    check("t5_done_count", 32'(dones), 1);
    check_all_x("t5", exp_x);
    run({8'd40, 8'd30, 8'd20, 8'd10}, cyc);
    check("t5_rerun_latency", 32'(cyc), 33);
    check("t5_rerun_x0", 32'(x0_o), 100);

    // Test 3: saturation, everything at 255 -> 2032 clamps to 1023
    fill_w(255);
    run({8'd255, 8'd255, 8'd255, 8'd255}, cyc);
    check("t3_latency", 32'(cyc), 33);
    for (int k = 0; k < 8; k++) exp_x[k] = 10'd1023;
    check_all_x("t3", exp_x);

    // Test 4: routing, only w[12] (h=3, j=0) nonzero
    fill_w(0);
    write_w(12, 64);
    run({8'd7, 8'd9, 8'd11, 8'd200}, cyc);
    check("t4_latency", 32'(cyc), 33);
    for (int k = 0; k < 8; k++) exp_x[k] = (k == 3) ? 10'd100 : 10'd0;
    check_all_x("t4", exp_x);

    // Test 6: reset at MAC cycle 10 aborts the run
    @(negedge clk_i);
    feat_i  = {8'd40, 8'd30, 8'd20, 8'd10};
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("t6_busy", 32'(busy_o), 0);
    check("t6_done", 32'(done_o), 0);
    for (int k = 0; k < 8; k++) exp_x[k] = 10'd0;
    check_all_x("t6_rst", exp_x);
    @(negedge clk_i);
    rst_i = 1'b1;
    dones = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    check("t6_no_done", 32'(dones), 0);
    run({8'd40, 8'd30, 8'd20, 8'd10}, cyc);
    check("t6_lost_latency", 32'(cyc), 33);
    check_all_x("t6_lost", exp_x);
    fill_w(128);
    run({8'd40, 8'd30, 8'd20, 8'd10}, cyc);
    check("t6_latency", 32'(cyc), 33);
    for (int k = 0; k < 8; k++) exp_x[k] = 10'd100;
    check_all_x("t6", exp_x);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
